// File: rtl/cva6_sq_pkg.sv
// Shared definitions for the commit store queue.
// Contents: default-configuration sizing localparams, the queue entry type
// (address, data, byte enables) and the wrap-around pointer increment helper.
package cva6_sq_pkg;

  localparam int unsigned SQ_DEPTH  = 7;
  localparam int unsigned SQ_ADDR_W = 32;
  localparam int unsigned SQ_DATA_W = 32;
  localparam int unsigned SQ_BE_W   = SQ_DATA_W / 8;
  localparam int unsigned PTR_W     = $clog2(SQ_DEPTH);

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_BE_W-1:0]   be;
  } sq_entry_t;

  // Depth need not be a power of two, so wrap by compare rather than overflow.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cva6_sq_storage.sv
// Entry register array for the commit store queue.
// One write port (we_i/waddr_i/w*_i) and one combinational read port
// (raddr_i -> r*_o). Storage is not reset.
// With CVA6_SQ_LOAD_CHECK_EN defined it also compares ld_addr_i against every
// entry selected by occ_i (word-granular) and reports any match on ld_hit_o.
module cva6_sq_storage
  import cva6_sq_pkg::*;
#(
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PW-1:0]     waddr_i,
  input  logic [ADDR_W-1:0] waddr_val_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   wbe_i,
  input  logic [PW-1:0]     raddr_i,
  output logic [ADDR_W-1:0] raddr_val_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [BE_W-1:0]   rbe_o
`ifdef CVA6_SQ_LOAD_CHECK_EN
  ,
  input  logic [DEPTH-1:0]  occ_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } entry_t;

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= '{addr: waddr_val_i, data: wdata_i, be: wbe_i};
    end
  end

  assign raddr_val_o = mem_q[raddr_i].addr;
  assign rdata_o     = mem_q[raddr_i].data;
  assign rbe_o       = mem_q[raddr_i].be;

`ifdef CVA6_SQ_LOAD_CHECK_EN
  localparam int unsigned LSB = $clog2(BE_W);

  always_comb begin
    ld_hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ_i[i] && (mem_q[i].addr[ADDR_W-1:LSB] == ld_addr_i[ADDR_W-1:LSB])) begin
        ld_hit_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cva6_commit_store_queue.sv
// Circular store queue between the LSU store path and the D-cache store port.
// Entries head->cmt are committed (drained to the cache via req_valid_o /
// req_ready_i); entries cmt->tail are speculative and are discarded by flush_i.
// Ports: clk_i, rst_ni (sync, active-low), flush_i, push_* (store in),
// commit_i/commit_ready_o, req_* (cache port), empty_o, count_o.
// Optional macro CVA6_SQ_LOAD_CHECK_EN adds ld_addr_i / ld_hit_o for
// load-vs-store address matching over all occupied entries.
module cva6_commit_store_queue
  import cva6_sq_pkg::*;
#(
  parameter  int unsigned DEPTH  = 7,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [ADDR_W-1:0]          push_addr_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic [BE_W-1:0]            push_be_i,
  input  logic                       commit_i,
  output logic                       commit_ready_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [ADDR_W-1:0]          req_addr_o,
  output logic [DATA_W-1:0]          req_data_o,
  output logic [BE_W-1:0]            req_be_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef CVA6_SQ_LOAD_CHECK_EN
  ,
  input  logic [ADDR_W-1:0]          ld_addr_i,
  output logic                       ld_hit_o
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d, spec_cnt_q, spec_cnt_d, total;
  logic          do_push, do_commit, do_issue;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [BE_W-1:0]   rd_be;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return PW'(wrap_inc(32'(p), DEPTH));
  endfunction

  assign total          = com_cnt_q + spec_cnt_q;
  assign push_ready_o   = (total < CW'(DEPTH)) && !flush_i;
  assign commit_ready_o = (spec_cnt_q != '0);
  assign req_valid_o    = (com_cnt_q != '0);
  assign empty_o        = (total == '0);
  assign count_o        = total;

  assign do_push   = push_valid_i && push_ready_o;
  assign do_commit = commit_i && commit_ready_o;
  assign do_issue  = req_valid_o && req_ready_i;

  always_comb begin
    head_d     = head_q;
    cmt_d      = cmt_q;
    tail_d     = tail_q;
    com_cnt_d  = com_cnt_q + CW'(do_commit) - CW'(do_issue);
    spec_cnt_d = spec_cnt_q + CW'(do_push) - CW'(do_commit);
    if (do_push)   tail_d = inc(tail_q);
    if (do_commit) cmt_d  = inc(cmt_q);
    if (do_issue)  head_d = inc(head_q);
    // Flush sees this cycle's commit: speculative region collapses onto new cmt.
    if (flush_i) begin
      tail_d     = cmt_d;
      spec_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q     <= '0;
      cmt_q      <= '0;
      tail_q     <= '0;
      com_cnt_q  <= '0;
      spec_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      cmt_q      <= cmt_d;
      tail_q     <= tail_d;
      com_cnt_q  <= com_cnt_d;
      spec_cnt_q <= spec_cnt_d;
    end
  end

`ifdef CVA6_SQ_LOAD_CHECK_EN
  logic [DEPTH-1:0] occ;
  logic             raw_hit;

  // Entry i is occupied when its distance from head is below the total count.
  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      int unsigned off;
      off    = (i >= 32'(head_q)) ? i - 32'(head_q) : i + DEPTH - 32'(head_q);
      occ[i] = (off < 32'(total));
    end
  end

  assign ld_hit_o = raw_hit && rst_ni;
`endif

  cva6_sq_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .PW     (PW)
  ) i_storage (
    .clk_i       (clk_i),
    .we_i        (do_push),
    .waddr_i     (tail_q),
    .waddr_val_i (push_addr_i),
    .wdata_i     (push_data_i),
    .wbe_i       (push_be_i),
    .raddr_i     (head_q),
    .raddr_val_o (rd_addr),
    .rdata_o     (rd_data),
    .rbe_o       (rd_be)
`ifdef CVA6_SQ_LOAD_CHECK_EN
    ,
    .occ_i       (occ),
    .ld_addr_i   (ld_addr_i),
    .ld_hit_o    (raw_hit)
`endif
  );

  // Storage is unreset; mask the head so idle outputs read zero.
  assign req_addr_o = req_valid_o ? rd_addr : '0;
  assign req_data_o = req_valid_o ? rd_data : '0;
  assign req_be_o   = req_valid_o ? rd_be   : '0;

`ifndef SYNTHESIS
  commit_without_spec: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> commit_ready_o);
`endif

endmodule

// File: tb/tb_cva6_commit_store_queue.sv
module tb_cva6_commit_store_queue;

  localparam int unsigned DEPTH = 7;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, push_valid_i, push_ready_o;
  logic [31:0] push_addr_i, push_data_i;
  logic [3:0]  push_be_i;
  logic        commit_i, commit_ready_o, req_valid_o, req_ready_i;
  logic [31:0] req_addr_o, req_data_o;
  logic [3:0]  req_be_o;
  logic        empty_o;
  logic [2:0]  count_o;
`ifdef CVA6_SQ_LOAD_CHECK_EN
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
`endif

  always #5 clk_i = ~clk_i;

  cva6_commit_store_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_addr_i    (push_addr_i),
    .push_data_i    (push_data_i),
    .push_be_i      (push_be_i),
    .commit_i       (commit_i),
    .commit_ready_o (commit_ready_o),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (req_ready_i),
    .req_addr_o     (req_addr_o),
    .req_data_o     (req_data_o),
    .req_be_o       (req_be_o),
    .empty_o        (empty_o),
    .count_o        (count_o)
`ifdef CVA6_SQ_LOAD_CHECK_EN
    ,
    .ld_addr_i      (ld_addr_i),
    .ld_hit_o       (ld_hit_o)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t spq[$];   // model: speculative entries, oldest first
  ent_t cq[$];    // scoreboard: committed entries awaiting issue
  bit   live = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare outputs at the falling edge, advance the model over the rising edge.
  task automatic cycle();
    int   tot;
    bit   pu, co, is;
    ent_t e;
    @(negedge clk_i);
    tot = cq.size() + spq.size();
    if (live) begin
      check("push_ready",   push_ready_o,   (tot < DEPTH) && !flush_i);
      check("commit_ready", commit_ready_o, spq.size() != 0);
      check("req_valid",    req_valid_o,    cq.size() != 0);
      check("count",        count_o,        tot);
      check("empty",        empty_o,        tot == 0);
      if (cq.size() != 0) begin
        check("req_addr", req_addr_o, cq[0].a);
        check("req_data", req_data_o, cq[0].d);
        check("req_be",   req_be_o,   cq[0].be);
      end
`ifdef CVA6_SQ_LOAD_CHECK_EN
      begin
        bit hit = 0;
        foreach (cq[i])  if (cq[i].a[31:2]  == ld_addr_i[31:2]) hit = 1;
        foreach (spq[i]) if (spq[i].a[31:2] == ld_addr_i[31:2]) hit = 1;
        check("ld_hit", ld_hit_o, hit && rst_ni);
      end
`endif
    end
    if (!rst_ni) begin
      spq.delete();
      cq.delete();
      live = 1;
    end else if (live) begin
      pu = push_valid_i && (tot < DEPTH) && !flush_i;
      co = commit_i && (spq.size() != 0);
      is = (cq.size() != 0) && req_ready_i;
      if (is) void'(cq.pop_front());
      if (co) begin
        e = spq.pop_front();
        cq.push_back(e);
      end
      if (flush_i) spq.delete();
      if (pu) spq.push_back('{push_addr_i, push_data_i, push_be_i});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    push_valid_i = 1; push_addr_i = a; push_data_i = d; push_be_i = be;
    cycle();
    push_valid_i = 0;
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      commit_i = 1;
      cycle();
    end
    commit_i = 0;
  endtask

  task automatic drain();
    req_ready_i = 1;
    for (int k = 0; k < 32 && (cq.size() != 0 || spq.size() != 0); k++) begin
      commit_i = (spq.size() != 0);
      cycle();
    end
    commit_i = 0;
    cycle();
    check("drained_empty", empty_o, 1);
  endtask

  task automatic do_reset();
    rst_ni = 0;
    cycle();
    cycle();
    rst_ni = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] ha, hd;
    logic [3:0]  hb;
    rst_ni = 0; flush_i = 0; push_valid_i = 0; commit_i = 0; req_ready_i = 0;
    push_addr_i = '0; push_data_i = '0; push_be_i = '0;
`ifdef CVA6_SQ_LOAD_CHECK_EN
    ld_addr_i = '0;
`endif
    do_reset();

    // Reset state
    check("rst_push_ready",   push_ready_o,   1);
    check("rst_commit_ready", commit_ready_o, 0);
    check("rst_req_valid",    req_valid_o,    0);
    check("rst_empty",        empty_o,        1);
    check("rst_count",        count_o,        0);
    check("rst_req_addr",     req_addr_o,     0);
    check("rst_req_data",     req_data_o,     0);
    check("rst_req_be",       req_be_o,       0);

    // Single store end to end
    req_ready_i = 1;
    push(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    check("t1_commit_ready", commit_ready_o, 1);
    commit_n(1);
    check("t1_valid",  req_valid_o, 1);
    check("t1_addr",   req_addr_o, 32'h8000_0000);
    check("t1_data",   req_data_o, 32'hDEAD_BEEF);
    check("t1_be",     req_be_o,   4'hF);
    cycle();
    check("t1_valid_drop", req_valid_o, 0);
    check("t1_empty",      empty_o,     1);

    // Fill without commit; extra push refused
    req_ready_i = 0;
    for (int i = 0; i < 7; i++) push(32'h100 + 32'(i) * 4, 32'hA000 + 32'(i), 4'(i + 1));
    check("full_ready", push_ready_o, 0);
    check("full_count", count_o, 7);
    push(32'hBAD0_0000, 32'hBAD, 4'h1);
    check("full_count_hold", count_o, 7);
    drain();

    // Push 4, commit 2, flush (with a push offered during flush)
    req_ready_i = 0;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i) * 4, 32'hB000 + 32'(i), 4'h3);
    commit_n(2);
    flush_i = 1; push_valid_i = 1; push_addr_i = 32'hF1F1_0000;
    cycle();
    flush_i = 0; push_valid_i = 0;
    check("flush_count", count_o, 2);
    check("flush_commit_ready", commit_ready_o, 0);
    check("flush_head", req_addr_o, 32'h2000);
    drain();

    // Advance pointers to 6 so the next three entries wrap 6 -> 0
    for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i) * 4, 32'hC000 + 32'(i), 4'h1);
    drain();

    // Back-pressure stability then drain with wrap
    req_ready_i = 0;
    for (int i = 0; i < 3; i++) push(32'h4000 + 32'(i) * 4, 32'hD000 + 32'(i), 4'h5 + 4'(i));
    commit_n(3);
    ha = req_addr_o; hd = req_data_o; hb = req_be_o;
    check("hold_addr_first", ha, 32'h4000);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_addr", req_addr_o, ha);
      check("hold_data", req_data_o, hd);
      check("hold_be",   req_be_o,   hb);
    end
    req_ready_i = 1;
    n = 0;
    for (int k = 0; k < 10 && cq.size() != 0; k++) begin
      cycle();
      n++;
    end
    check("drain_cycles", n, 3);
    check("drain_empty", empty_o, 1);

    // Push + commit + issue in one cycle at 1 committed / 2 speculative
    req_ready_i = 0;
    push(32'h5000, 32'h1, 4'h1);
    push(32'h5004, 32'h2, 4'h2);
    push(32'h5008, 32'h3, 4'h4);
    commit_n(1);
    check("simul_pre_count", count_o, 3);
    req_ready_i = 1; commit_i = 1; push_valid_i = 1;
    push_addr_i = 32'h500C; push_data_i = 32'h4; push_be_i = 4'h8;
    cycle();
    push_valid_i = 0; commit_i = 0; req_ready_i = 0;
    check("simul_count", count_o, 3);
    check("simul_head", req_addr_o, 32'h5004);
    check("simul_commit_ready", commit_ready_o, 1);
    drain();

    // Reset in the middle of a drain
    req_ready_i = 0;
    for (int i = 0; i < 5; i++) push(32'h6000 + 32'(i) * 4, 32'hE000 + 32'(i), 4'hF);
    commit_n(5);
    req_ready_i = 1;
    cycle();
    rst_ni = 0;
    cycle();
    rst_ni = 1;
    check("midrst_empty", empty_o, 1);
    check("midrst_valid", req_valid_o, 0);
    check("midrst_count", count_o, 0);
    cycle();

`ifdef CVA6_SQ_LOAD_CHECK_EN
    req_ready_i = 0;
    push(32'h1004, 32'h77, 4'hF);
    ld_addr_i = 32'h1006;
    #1;
    check("ld_hit_same_word", ld_hit_o, 1);
    ld_addr_i = 32'h1008;
    #1;
    check("ld_hit_next_word", ld_hit_o, 0);
    ld_addr_i = 32'h1004;
    commit_n(1);
    check("ld_hit_committed", ld_hit_o, 1);
    drain();
    check("ld_hit_after_drain", ld_hit_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cva6_commit_store_queue.md
Name: cva6_commit_store_queue

Overview:
- Circular store queue between the load/store unit's store path and the data-cache store port.
- Holds speculative stores until commit, then drains committed stores in order to the cache using a valid/ready handshake.
- On a pipeline flush it discards all uncommitted entries and keeps committed ones.
- Default depth matches the core's maximum outstanding stores (7); widths follow XLEN.

Parameters:
- DEPTH, 7, number of entries; any value ≥2, not necessarily a power of two.
- ADDR_W, 32, physical address width of an entry.
- DATA_W, 32, store data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width (derived, not overridable).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  discard all speculative (uncommitted) entries.
- push_valid_i  in  1  new speculative store offered.
- push_ready_o  out  1  queue can accept a store this cycle.
- push_addr_i  in  ADDR_W  store address.
- push_data_i  in  DATA_W  store data.
- push_be_i  in  BE_W  byte enables.
- commit_i  in  1  commit oldest speculative entry.
- commit_ready_o  out  1  at least one speculative entry exists.
- req_valid_o  out  1  committed store presented to cache.
- req_ready_i  in  1  cache accepts the store.
- req_addr_o  out  ADDR_W  address of the head entry.
- req_data_o  out  DATA_W  data of the head entry.
- req_be_o  out  BE_W  byte enables of the head entry.
- empty_o  out  1  no entries of any kind.
- count_o  out  $clog2(DEPTH+1)  total occupied entries.

Behaviour:
- State: pointers head_q, cmt_q, tail_q (each mod DEPTH); counters com_cnt_q (committed, not yet issued) and spec_cnt_q (speculative). Entries are ordered head → cmt (committed), then cmt → tail (speculative).
- All state updates on the rising edge of clk_i. All pointer increments wrap from DEPTH-1 to 0 by explicit compare, not by bit overflow.
- Reset (rst_ni=0 at the edge): all pointers and counters cleared. Outputs then read push_ready_o=1, commit_ready_o=0, req_valid_o=0, empty_o=1, count_o=0, and req_addr/data/be_o=0. Entry storage is not reset.
- push_ready_o = (com_cnt_q+spec_cnt_q < DEPTH) && !flush_i.
  - A push occurs when push_valid_i && push_ready_o.
  - It writes the entry at tail_q, increments tail_q, and increments spec_cnt_q.
- commit_ready_o = spec_cnt_q ≠ 0.
  - A commit occurs when commit_i && commit_ready_o: cmt_q++, spec_cnt_q--, com_cnt_q++.
  - commit_i while commit_ready_o=0 is ignored; a verification assertion flags it.
- req_valid_o = com_cnt_q ≠ 0. req_addr/data/be_o are the head entry, driven combinationally from storage.
  - An issue occurs when req_valid_o && req_ready_i: head_q++, com_cnt_q--.
  - While req_valid_o=1 and req_ready_i=0, the req_* outputs must stay stable.
- Latency:
  - An entry committed at edge N can issue at the earliest in the cycle after N.
  - A push and a commit of the same entry cannot happen in the same cycle; a pushed entry is committable from the next cycle.
- Simultaneous events:
  - Push, commit and issue may all happen in one cycle; the counters net correctly (e.g. com_cnt_q unchanged on commit + issue).
  - Full queue with an issue in the same cycle: push is still refused, because ready is based on registered counts only.
- flush_i:
  - The commit in that cycle (if any) is applied first.
  - Then tail_q ← new cmt value and spec_cnt_q ← 0.
  - Any push in that cycle is refused.
  - Issue proceeds normally.
- empty_o = (com_cnt_q+spec_cnt_q == 0). count_o = com_cnt_q+spec_cnt_q.

Optional Feature:
- Macro CVA6_SQ_LOAD_CHECK_EN.
- Defined: adds ports ld_addr_i (in, ADDR_W) and ld_hit_o (out, 1).
  - ld_hit_o=1 combinationally when any occupied entry, committed or speculative, has an address equal to ld_addr_i on bits [ADDR_W-1:$clog2(BE_W)].
  - The load unit stalls on a hit. ld_hit_o=0 during reset.
- Undefined: the ports and comparators are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cva6_sq_pkg holds:
  - the sq_entry_t typedef (addr, data, be), parameterised through localparams;
  - the pointer width localparam PTR_W=$clog2(DEPTH);
  - a wrap-increment function.
- One sub-module, cva6_sq_storage: the DEPTH-entry register array with one write port (tail) and one read port (head).
  - Under the macro it also provides all-entry address comparison, qualified by an occupancy mask.

Test Plan:
- Reset, then push 0x8000_0000 / data 0xDEADBEEF / be 0xF, commit next cycle, req_ready_i=1 → req_valid_o high for exactly one cycle with those values; empty_o returns to 1.
- Push 7 stores without commit → push_ready_o=0 and count_o=7 at the end; an 8th push_valid_i is ignored and count_o stays 7.
- Push 4, commit 2, flush → count_o=2, commit_ready_o=0; only the first two addresses drain, in order.
- Hold req_ready_i=0 for 5 cycles with 3 committed entries → req_* outputs stable; releasing it drains 3 entries in 3 cycles, including a pointer wrap 6→0.
- Push + commit + issue in the same cycle at count 3 (1 committed, 2 speculative) → count_o stays 3; com_cnt 1→1, spec_cnt 2→2.
- Assert rst_ni mid-drain with 5 entries held → next cycle empty_o=1 and req_valid_o=0.
- With CVA6_SQ_LOAD_CHECK_EN: push to 0x1004, then ld_addr_i=0x1006 → ld_hit_o=1; ld_addr_i=0x1008 → ld_hit_o=0.
